// File: rtl/aes_axi_stream_master.sv
// aes_axi_stream_master: buffers 128-bit AES result blocks and serialises each into four 32-bit AXI4-Stream beats.
module aes_axi_stream_master #(
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int FIFO_DATA_WIDTH      = 128,
  parameter int BUF_DEPTH            = 4,
  parameter int BUF_ADDR_WIDTH       = 2
) (
  input  logic                              m00_axis_aclk,
  input  logic                              m00_axis_aresetn,
  input  logic                              aes_blk_wvalid,
  output logic                              aes_blk_wready,
  input  logic [FIFO_DATA_WIDTH-1:0]        aes_blk_wdata,
  input  logic                              aes_blk_last,
  output logic                              m00_axis_tvalid,
  input  logic                              m00_axis_tready,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                              m00_axis_tlast,
  output logic                              axis_master_done,
  output logic                              axis_master_busy
);
  localparam int W = C_M_AXIS_TDATA_WIDTH;
  localparam logic [BUF_ADDR_WIDTH:0]   CNT_FULL = BUF_DEPTH[BUF_ADDR_WIDTH:0];
  localparam logic [BUF_ADDR_WIDTH:0]   CNT_ONE  = 1;
  localparam logic [BUF_ADDR_WIDTH-1:0] PTR_ONE  = 1;
  typedef enum logic {IDLE, SEND} state_t;
  logic [FIFO_DATA_WIDTH:0]  mem_q [BUF_DEPTH];
  logic [BUF_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_nxt;
  logic [BUF_ADDR_WIDTH:0]   count_q, count_d;
  state_t                    state_q, state_d;
  logic [1:0]                beat_q, beat_d;
  logic                      tvalid_q, tvalid_d, tlast_q, tlast_d, done_q, done_d;
  logic [W-1:0]              tdata_q, tdata_d;
  logic                      push, pop, hs;
  logic [FIFO_DATA_WIDTH:0]  head, nxt;
  assign aes_blk_wready   = count_q != CNT_FULL;
  assign push             = aes_blk_wvalid && aes_blk_wready;
  assign hs               = tvalid_q && m00_axis_tready;
  assign pop              = hs && state_q == SEND && beat_q == 2'd3;
  assign rd_nxt           = rd_ptr_q + PTR_ONE;
  assign head             = mem_q[rd_ptr_q];
  assign nxt              = mem_q[rd_nxt];
  assign m00_axis_tvalid  = tvalid_q;
  assign m00_axis_tdata   = tdata_q;
  assign m00_axis_tlast   = tlast_q;
  assign m00_axis_tstrb   = '1;
  assign axis_master_done = done_q;
  assign axis_master_busy = count_q != '0 || tvalid_q;
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    done_d   = hs && tlast_q;
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop ? rd_nxt : rd_ptr_q;
    count_d  = (push && !pop) ? count_q + CNT_ONE : (pop && !push) ? count_q - CNT_ONE : count_q;
    if (state_q == IDLE) begin
      if (count_q != '0) begin
        state_d  = SEND;
        tvalid_d = 1'b1;
        beat_d   = 2'd0;
        tdata_d  = head[W-1:0];
        tlast_d  = 1'b0;
      end
    end else if (hs) begin
      if (beat_q != 2'd3) begin
        beat_d  = beat_q + 2'd1;
        tdata_d = head[{beat_d, 5'd0} +: W];
        tlast_d = beat_d == 2'd3 && head[FIFO_DATA_WIDTH];
      end else begin
        // a same-cycle write is not visible yet, so only entries already counted chain on
        beat_d  = 2'd0;
        tlast_d = 1'b0;
        if (count_q > CNT_ONE) begin
          tdata_d = nxt[W-1:0];
        end else begin
          tvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
    end
  end
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      done_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
      done_q   <= done_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  always_ff @(posedge m00_axis_aclk) begin
    if (push) mem_q[wr_ptr_q] <= {aes_blk_last, aes_blk_wdata};
  end
endmodule

// File: tb/tb_aes_axi_stream_master.sv
// tb_aes_axi_stream_master: directed bench with a beat-queue model checked every cycle plus literal expectations.
module tb_aes_axi_stream_master;
  logic         clk = 0, rst_n = 0, wvalid = 0, wlast = 0, tready = 0;
  logic         wready, tvalid, tlast, done, busy;
  logic [127:0] wdata = '0;
  logic [31:0]  tdata;
  logic [3:0]   tstrb;
  int           errors = 0, checks = 0;
  logic [31:0]  exp_d[$];
  logic         exp_l[$];
  logic [31:0]  got_d[$];
  logic         got_l[$];
  int           got_c[$];
  int           mcount = 0, bcnt = 0, cyc = 0;
  logic         prev_last = 0;

  aes_axi_stream_master dut (
    .m00_axis_aclk(clk), .m00_axis_aresetn(rst_n),
    .aes_blk_wvalid(wvalid), .aes_blk_wready(wready), .aes_blk_wdata(wdata), .aes_blk_last(wlast),
    .m00_axis_tvalid(tvalid), .m00_axis_tready(tready), .m00_axis_tdata(tdata), .m00_axis_tstrb(tstrb),
    .m00_axis_tlast(tlast), .axis_master_done(done), .axis_master_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  function automatic logic [127:0] mk(input int b);
    logic [127:0] r;
    for (int w = 0; w < 4; w++) r[32*w +: 32] = 32'hB000_0000 | (b << 8) | w;
    return r;
  endfunction

  // Model: a queue of beats owed to the DMA and a count of blocks not yet fully sent.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_d.delete();
      exp_l.delete();
      mcount = 0;
      bcnt = 0;
      prev_last = 0;
    end else begin
      chk("wready", wready, mcount != 4);
      chk("busy", busy, mcount != 0);
      chk("done", done, prev_last);
      chk("tstrb", tstrb, 4'hF);
      if (tvalid) begin
        if (exp_d.size() == 0) chk("tvalid_unexpected", tvalid, 0);
        else begin
          chk("tdata", tdata, exp_d[0]);
          chk("tlast", tlast, exp_l[0]);
        end
      end
      prev_last = tvalid && tready && tlast;
      if (tvalid && tready && exp_d.size() != 0) begin
        got_d.push_back(tdata);
        got_l.push_back(tlast);
        got_c.push_back(cyc);
        void'(exp_d.pop_front());
        void'(exp_l.pop_front());
        bcnt = (bcnt + 1) % 4;
        if (bcnt == 0) mcount--;
      end
      if (wvalid && wready) begin
        for (int w = 0; w < 4; w++) begin
          exp_d.push_back(wdata[32*w +: 32]);
          exp_l.push_back(wlast && w == 3);
        end
        mcount++;
      end
      cyc++;
    end
  end

  task automatic push(input logic [127:0] d, input logic l);
    logic ok = 0;
    wvalid = 1;
    wdata = d;
    wlast = l;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = wready;
      @(posedge clk);
      #1;
    end
    wvalid = 0;
    chk("push_ok", ok, 1);
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 400; i++) begin
      if (exp_d.size() == 0 && !tvalid && !busy) break;
      @(posedge clk);
      #1;
    end
    chk("drain", i < 400, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_tvalid();
    int i;
    for (i = 0; i < 50 && !tvalid; i++) begin
      @(posedge clk);
      #1;
    end
    chk("wait_tvalid", tvalid, 1);
  endtask

  task automatic clear_got();
    got_d.delete();
    got_l.delete();
    got_c.delete();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    chk("rst_tvalid", tvalid, 0);
    chk("rst_wready", wready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tlast", tlast, 0);

    // single last block
    tready = 1;
    clear_got();
    push(128'h33333333_22222222_11111111_00000000, 1);
    drain();
    chk("single_n", got_d.size(), 4);
    if (got_d.size() == 4) begin
      chk("single_b0", got_d[0], 32'h00000000);
      chk("single_b1", got_d[1], 32'h11111111);
      chk("single_b2", got_d[2], 32'h22222222);
      chk("single_b3", got_d[3], 32'h33333333);
      chk("single_l0", got_l[0], 0);
      chk("single_l3", got_l[3], 1);
    end

    // three back-to-back blocks, no bubble
    clear_got();
    push(mk(0), 0);
    push(mk(1), 0);
    push(mk(2), 1);
    drain();
    chk("three_n", got_d.size(), 12);
    if (got_d.size() == 12) begin
      for (int i = 1; i < 12; i++) chk("three_gap", got_c[i] - got_c[i-1], 1);
      chk("three_l3", got_l[3], 0);
      chk("three_l11", got_l[11], 1);
      chk("three_b4", got_d[4], 32'hB000_0100);
      chk("three_b11", got_d[11], 32'hB000_0203);
    end

    // stall for 5 cycles on beat 2
    tready = 0;
    clear_got();
    push(mk(5), 1);
    wait_tvalid();
    tready = 1;
    repeat (2) @(posedge clk);
    #1 tready = 0;
    repeat (5) begin
      @(negedge clk);
      chk("stall_tvalid", tvalid, 1);
      chk("stall_tdata", tdata, 32'hB000_0502);
    end
    @(posedge clk);
    #1 tready = 1;
    drain();
    chk("stall_n", got_d.size(), 4);
    if (got_d.size() == 4) chk("stall_b2", got_d[2], 32'hB000_0502);

    // fill the buffer while stalled
    tready = 0;
    clear_got();
    for (int b = 10; b < 14; b++) push(mk(b), b == 13);
    wvalid = 1;
    wdata = mk(14);
    wlast = 1;
    repeat (3) begin
      @(negedge clk);
      chk("full_wready", wready, 0);
      @(posedge clk);
      #1;
    end
    wvalid = 0;
    tready = 1;
    drain();
    chk("full_n", got_d.size(), 16);
    if (got_d.size() == 16) begin
      for (int i = 0; i < 16; i++) chk("full_order", got_d[i], 32'hB000_0000 | ((10 + i / 4) << 8) | (i % 4));
      chk("full_b15", got_d[15], 32'hB000_0D03);
      chk("full_l15", got_l[15], 1);
      chk("full_l11", got_l[11], 0);
    end

    // reset in the middle of beat 2
    tready = 1;
    push(mk(20), 0);
    push(mk(21), 1);
    begin
      int i;
      for (i = 0; i < 50 && !(tvalid && tdata == 32'hB000_1402); i++) begin
        @(posedge clk);
        #1;
      end
      chk("rst_reach_b2", i < 50, 1);
    end
    #2 rst_n = 0;
    #1 chk("rst_async_tvalid", tvalid, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    chk("rst2_wready", wready, 1);
    chk("rst2_busy", busy, 0);
    repeat (10) begin
      @(negedge clk);
      chk("rst2_stale", tvalid, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
